pattern_det_ctrl: RTL and testbench
===================================

# pattern_det_ctrl

Run controller for the serial pattern detector used alongside the Moore non-overlapping FSMs. It holds a programmable pattern and length, and sequences one detection run over a frame of N serial bits using a valid/ready handshake. It counts non-overlapping matches and signals completion with a one-cycle `done` pulse. Upstream logic configures it while idle, issues `start`, streams bits and then reads `match_count`.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (2..16).
- `CNT_W`, default 8: width of `frame_len` and `match_count`.
- `LEN_W`, default $clog2(PAT_W+1): width of `cfg_len`.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cfg_we`  in  1: pattern/length write strobe, honoured in IDLE only.
- `cfg_pattern`  in  PAT_W: pattern; bit 0 is the last-received bit of a match.
- `cfg_len`  in  LEN_W: pattern length; 0 or >PAT_W is stored as PAT_W.
- `start`  in  1: begin a run, honoured in IDLE only.
- `frame_len`  in  CNT_W: number of bits in the run; sampled with `start`.
- `bit_valid`  in  1: `bit_in` is valid.
- `bit_in`  in  1: serial data bit.
- `bit_ready`  out  1: high only in RUN.
- `busy`  out  1: high in LOAD and RUN.
- `match_pulse`  out  1: one-cycle pulse per detected match (registered, Moore).
- `match_count`  out  CNT_W: matches counted in the current/last run.
- `done`  out  1: one-cycle pulse when the run ends.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE + `start` & `frame_len`≠0 → LOAD.
  - IDLE + `start` & `frame_len`=0 → DONE, with `match_count` cleared.
  - LOAD → RUN unconditionally. LOAD clears the history register, history fill count and `match_count`, and loads `remaining` with `frame_len`.
  - RUN → DONE on the accept of the last bit (`remaining`=1).
  - DONE → IDLE unconditionally.
- A bit is accepted when `bit_valid` & `bit_ready`. On accept:
  - `hist <= {hist[PAT_W-2:0], bit_in}`
  - `fill` increments, saturating at PAT_W.
  - `remaining` decrements.
- Match condition, evaluated on the post-shift values: `fill`≥len and `hist[len-1:0] == pattern[len-1:0]`.
- On a match: `match_pulse` is set next cycle, `match_count` increments (saturating at 2^CNT_W-1), and `fill` resets to 0. Resetting `fill` makes detection non-overlapping: bits of a matched pattern are never reused.
- `cfg_we` and `start` outside IDLE are ignored. If both are asserted in the same IDLE cycle, the config write occurs and the run uses the NEW pattern.
- `match_count` holds its value after DONE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE.
  - pattern = 'b101, len = 3.
  - `bit_ready`, `busy`, `match_pulse`, `done` = 0.
  - `match_count` = 0; `hist`, `fill`, `remaining` = 0.
- Sequence: `start` sampled at cycle t → `busy` from t+1 (LOAD) → `bit_ready` from t+2 (RUN).
- Match latency: a bit accepted at cycle k that completes a match gives `match_pulse`=1 and the updated `match_count` at k+1.
- Last bit accepted at cycle k: `done`=1 at k+1, coinciding with `match_pulse` if that bit matched. `busy` and `bit_ready` are 0 at k+1. `start` is honoured again from k+2.
- `bit_valid` gaps stall RUN indefinitely and do not time out.
- `rst` mid-run: the FSM is in IDLE the next cycle, `match_count` is 0, and all pulses are dropped.

## Configuration
- `FIRST_MATCH_STOP_EN` defined: the first match in RUN ends the run. FSM goes to DONE next cycle; `done` and `match_pulse` coincide; `match_count`=1; remaining bits are not accepted (`bit_ready`=0).
- `FIRST_MATCH_STOP_EN` undefined: the run always consumes exactly `frame_len` bits.

## Test plan
- After reset (pattern 101, len 3), `frame_len`=5, bits 1,0,1,0,1 with `bit_valid` held high → exactly one `match_pulse` (after the 3rd bit), `done` one cycle after the 5th accept, `match_count`=1 (the overlap at bits 3–5 is rejected).
- `frame_len`=6, bits 1,0,1,1,0,1 with random `bit_valid` gaps → two pulses, `match_count`=2, `done` exactly once.
- `cfg_we` with pattern 'b0110, len 4 in IDLE, then a run of 0,1,1,0,1,1,0 (7 bits) → `match_count`=1. A `cfg_we` with 'b1111 issued during RUN does not alter the result.
- `start` with `frame_len`=0 → `done` at t+1, `busy` never high, `match_count`=0. A second `start` while `busy` is ignored (a single `done`).
- `rst` asserted after 2 of 5 accepted bits → IDLE next cycle, all outputs at reset values, pattern back to 101. A fresh run then works normally.
- With `FIRST_MATCH_STOP_EN`, `frame_len`=8, bits 1,0,1,… → `done` and `match_pulse` in the same cycle after the 3rd accept, `match_count`=1, and `bit_ready` low thereafter.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// Run controller for the serial pattern detector: it holds a configurable pattern and length,
// and counts non-overlapping matches over a frame of N bits. Optional macro FIRST_MATCH_STOP_EN
// ends the run on the first match.
module pattern_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic [PAT_W-2:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] match_count_r;
  logic             match_pulse_r;
  logic             done_r;
  logic             busy_r;
  logic             bit_ready_r;

  logic             accept_s;
  logic [PAT_W-1:0] hist_nxt_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic             match_s;
  logic             stop_s;

  assign accept_s   = bit_valid & bit_ready_r;
  // The full window is the stored history plus the bit being accepted this cycle.
  assign hist_nxt_s = {hist_r, bit_in};

  // Saturating fill increment and the length mask used for the pattern compare
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    if (fill_r == LEN_W'(PAT_W)) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
    match_s = (fill_inc_s >= len_r) &&
              (((hist_nxt_s ^ pattern_r) & mask_s) == {PAT_W{1'b0}});
  end

`ifdef FIRST_MATCH_STOP_EN
  assign stop_s = match_s;
`else
  assign stop_s = 1'b0;
`endif

  // Run-control FSM with configuration, history, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pattern_r     <= PAT_W'(3'b101);
      len_r         <= LEN_W'(3);
      hist_r        <= {(PAT_W-1){1'b0}};
      fill_r        <= {LEN_W{1'b0}};
      remaining_r   <= {CNT_W{1'b0}};
      match_count_r <= {CNT_W{1'b0}};
      match_pulse_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      bit_ready_r   <= 1'b0;
    end else begin
      match_pulse_r <= 1'b0;
      done_r        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            pattern_r <= cfg_pattern;
            if (cfg_len == {LEN_W{1'b0}} || cfg_len > LEN_W'(PAT_W)) begin
              len_r <= LEN_W'(PAT_W);
            end else begin
              len_r <= cfg_len;
            end
          end
          if (start) begin
            remaining_r <= frame_len;
            if (frame_len != {CNT_W{1'b0}}) begin
              state_r <= LOAD;
              busy_r  <= 1'b1;
            end else begin
              state_r       <= DONE;
              done_r        <= 1'b1;
              match_count_r <= {CNT_W{1'b0}};
            end
          end
        end
        LOAD: begin
          hist_r        <= {(PAT_W-1){1'b0}};
          fill_r        <= {LEN_W{1'b0}};
          match_count_r <= {CNT_W{1'b0}};
          state_r       <= RUN;
          bit_ready_r   <= 1'b1;
        end
        RUN: begin
          if (accept_s) begin
            hist_r      <= hist_nxt_s[PAT_W-2:0];
            remaining_r <= remaining_r - CNT_W'(1);
            if (match_s) begin
              // Restarting the fill count keeps matched bits from being reused.
              fill_r        <= {LEN_W{1'b0}};
              match_pulse_r <= 1'b1;
              if (match_count_r != {CNT_W{1'b1}}) begin
                match_count_r <= match_count_r + CNT_W'(1);
              end
            end else begin
              fill_r <= fill_inc_s;
            end
            if (remaining_r == CNT_W'(1) || stop_s) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              bit_ready_r <= 1'b0;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          bit_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready   = bit_ready_r;
  assign busy        = busy_r;
  assign match_pulse = match_pulse_r;
  assign match_count = match_count_r;
  assign done        = done_r;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Randomized self-checking bench for pattern_det_ctrl against a frame-level match model.
module tb_pattern_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             start;
  logic [CNT_W-1:0] frame_len;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;

  int checks = 0;
  int failures = 0;

  logic [PAT_W-1:0] mpat;
  int               mlen;
  bit               tb_bits[0:255];
  bit               exp_pulse[0:255];
  int               exp_last;

  pattern_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .frame_len(frame_len), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scan the frame: a match needs len bits since the previous match whose reverse order equals the pattern.
  function automatic int model(input int n);
    int run = 0;
    int cnt = 0;
    bit ok;
    exp_last = n - 1;
    for (int i = 0; i < n; i++) begin
      exp_pulse[i] = 1'b0;
      run++;
      if (run >= mlen) begin
        ok = 1'b1;
        for (int j = 0; j < mlen; j++) begin
          if (tb_bits[i - j] != mpat[j]) ok = 1'b0;
        end
        if (ok) begin
          exp_pulse[i] = 1'b1;
          cnt++;
          run = 0;
`ifdef FIRST_MATCH_STOP_EN
          exp_last = i;
          return cnt;
`endif
        end
      end
    end
    return cnt;
  endfunction

  function automatic int clamp_len(input int l);
    return (l == 0 || l > PAT_W) ? PAT_W : l;
  endfunction

  task automatic write_cfg(input logic [PAT_W-1:0] p, input int l);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mpat = p; mlen = clamp_len(l);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, bit_ready, 0);
    check_eq({tag, "_pulse"}, match_pulse, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_count"}, match_count, 0);
  endtask

  // One run of n bits from tb_bits; noise pokes cfg_we/start during RUN; abort_at>0 resets after that many accepts.
  task automatic do_run(input int n, input int gap_pct, input bit noise, input int abort_at,
                        input bit wcfg, input logic [PAT_W-1:0] wpat, input int wlen);
    int  exp_cnt;
    int  acc = 0;
    int  cyc = 0;
    bit  acc_now;
    bit  done_seen = 1'b0;
    if (wcfg) begin
      cfg_we = 1'b1; cfg_pattern = wpat; cfg_len = LEN_W'(wlen);
      mpat = wpat; mlen = clamp_len(wlen);
    end
    exp_cnt = model(n);
    start = 1'b1; frame_len = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    if (n == 0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_count", match_count, 0);
      @(posedge clk); #1;
      check_eq("zero_done_once", done, 0);
      check_eq("zero_busy_after", busy, 0);
      return;
    end
    check_eq("load_busy", busy, 1);
    check_eq("load_ready", bit_ready, 0);
    @(posedge clk); #1;
    check_eq("run_ready", bit_ready, 1);
    check_eq("run_count_clr", match_count, 0);
    while (!done_seen && cyc < 2000) begin
      bit_valid = ($urandom_range(99) >= gap_pct);
      bit_in = tb_bits[acc];
      if (noise) begin
        cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = LEN_W'(4);
        start = 1'b1; frame_len = n[CNT_W-1:0];
      end
      @(posedge clk); #1;
      cyc++;
      acc_now = bit_valid;
      bit_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
      if (acc_now) begin
        check_eq("pulse", match_pulse, exp_pulse[acc]);
        check_eq("done_at_last", done, (acc == exp_last));
        if (acc == exp_last) done_seen = 1'b1;
        acc++;
        if (abort_at > 0 && acc == abort_at && !done_seen) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          check_idle_outputs("abort");
          mpat = PAT_W'(3'b101); mlen = 3;
          return;
        end
      end else begin
        check_eq("stall_pulse", match_pulse, 0);
        check_eq("stall_done", done, 0);
      end
    end
    if (!done_seen) check_eq("run_timeout", 0, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_ready", bit_ready, 0);
    check_eq("end_count", match_count, exp_cnt);
    @(posedge clk); #1;
    check_eq("done_once", done, 0);
    check_eq("post_pulse", match_pulse, 0);
    check_eq("hold_count", match_count, exp_cnt);
  endtask

  task automatic load_bits(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) tb_bits[i] = v[n - 1 - i];
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; start = 1'b0;
    frame_len = '0; bit_valid = 1'b0; bit_in = 1'b0;
    mpat = PAT_W'(3'b101); mlen = 3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");

    load_bits(5, 32'b10101);
    do_run(5, 0, 1'b0, 0, 1'b0, '0, 0);
    load_bits(6, 32'b101101);
    do_run(6, 40, 1'b0, 0, 1'b0, '0, 0);

    write_cfg(8'b0110, 4);
    load_bits(7, 32'b0110110);
    do_run(7, 20, 1'b1, 0, 1'b0, '0, 0);

    do_run(0, 0, 1'b0, 0, 1'b0, '0, 0);

    for (int i = 0; i < 5; i++) tb_bits[i] = 1'($urandom_range(1));
    do_run(5, 0, 1'b0, 2, 1'b0, '0, 0);
    load_bits(5, 32'b10101);
    do_run(5, 10, 1'b0, 0, 1'b0, '0, 0);

    load_bits(8, 32'b10101010);
    do_run(8, 0, 1'b0, 0, 1'b0, '0, 0);

    for (int r = 0; r < 25; r++) begin
      int n;
      int l;
      logic [PAT_W-1:0] p;
      n = $urandom_range(1, 40);
      l = $urandom_range(0, 15);
      p = PAT_W'($urandom);
      for (int i = 0; i < n; i++) tb_bits[i] = 1'($urandom_range(1));
      if (r % 3 == 0) begin
        do_run(n, 30, 1'b0, 0, 1'b1, p, $urandom_range(1, 4));
      end else if (r % 3 == 1) begin
        write_cfg(p, l);
        do_run(n, 30, 1'b1, 0, 1'b0, '0, 0);
      end else begin
        write_cfg(p, $urandom_range(1, 3));
        do_run(n, 0, 1'b0, 0, 1'b0, '0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
